frame_scanout: RTL and testbench
================================

# frame_scanout

Read-side display controller for the frame-buffer path. The write side fills the pixel RAM at address {y,x}. This block scans that RAM back out in raster order and produces display-ready output: X, Y, 15-bit RGB, data-enable, and active-low hsync/vsync. It also starts and stops cleanly on a frame-valid handshake from the writer.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixel ticks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- PIX_W, 15, RGB width

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  pixel tick; counters and output stage advance only on clk edges with en=1
- frame_valid  in  1  level from writer: frame buffer contents are complete and may be scanned
- rd_en  out  1  RAM read strobe (combinational)
- rd_addr  out  20  RAM read address {v_cnt[9:0], h_cnt[9:0]} (combinational)
- rd_data  in  PIX_W  RAM read data; valid one clk after rd_en, held until the next rd_en
- RGB_out  out  PIX_W  pixel colour; 0 when not de
- X  out  10  column of the pixel currently on RGB_out
- Y  out  10  row of the pixel currently on RGB_out
- de  out  1  data enable (active region)
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- frame_done  out  1  one-clk pulse at end of each scanned frame

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both totals must be ≤ 1024.
- Counters:
  - h_cnt counts 0..H_TOTAL-1 on en and wraps to 0.
  - On each h wrap, v_cnt counts 0..V_TOTAL-1 and wraps to 0.
- Position flags, decoded from the counters:
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hs_n = 0 iff H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vs_n = 0 iff V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC
- FSM states: IDLE, SCAN.
  - IDLE: counters held at 0; rd_en=0; de=0; hsync=vsync=1; RGB_out=0.
  - IDLE → SCAN on any clk with frame_valid=1. The first en tick in SCAN processes position (0,0).
  - SCAN: on each en, register the current flags into the output stage, then advance the counters.
  - End of frame is the en tick at h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1. On that tick:
    - frame_done=1 on the following clk, for one clk.
    - Counters wrap to 0.
    - If frame_valid=1 on that tick, stay in SCAN (back-to-back frames with no gap). Otherwise go to IDLE.
  - frame_valid falling mid-frame does not abort the frame; the current frame always completes.
- RAM read: rd_en = en && active && (state==SCAN); rd_addr = {v_cnt, h_cnt}. No reads in blanking.
- Output stage (registered, updated on en in SCAN): X←h_cnt, Y←v_cnt, de←active, hsync←hs_n, vsync←vs_n.
- RGB_out = de ? rd_data : 0.
- On the clk returning to IDLE, the output stage clears to its IDLE values.

## Timing
- Reset values: state=IDLE, h_cnt=v_cnt=0, X=Y=0, de=0, hsync=vsync=1, rd_en=0, RGB_out=0, frame_done=0.
- rst has priority over en and frame_valid. Reset mid-frame returns every output to its reset value on the next clk; scanning restarts at (0,0) only once frame_valid is seen again.
- Latency: rd_en/rd_addr for position (h,v) are presented on clk edge k (with en). X/Y/de/sync and RGB_out for (h,v) are valid after edge k. rd_data arrives one clk after rd_en.
- With en=1 continuously, one pixel per clk with no bubbles. With a sparse en, outputs hold between ticks, and RGB_out stays correct because RAM data is held.
- frame_done and the IDLE transition happen on the end-of-frame tick edge. frame_valid sampled on that same edge decides continuation.

## Test plan
Small parameters for all tests: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=8); V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=6). The RAM model returns {y,x}-derived data.

1. **Reset and idle:** rst=1 for 3 clks, then frame_valid=0 with en=1 for 20 clks → hsync=vsync=1, de=0, rd_en=0, RGB_out=0, X=Y=0 throughout.
2. **Single frame:** frame_valid=1 for one clk, en=1 continuously → rd_en high on exactly 12 ticks with addresses {0,0}..{2,3} in raster order.
   - de high on the matching 12 output cycles; RGB_out matches RAM[{Y,X}].
   - hsync low for 2 clks per line, at h=5..6; vsync low for line 4 (8 clks).
   - frame_done pulses once after 48 ticks; FSM returns to IDLE.
3. **Back-to-back frames:** frame_valid held at 1 → two consecutive frames with no gap; the second frame's (0,0) pixel is on the tick immediately after end of frame; frame_done pulses twice, 48 ticks apart.
4. **Sparse en:** en=1 every third clk → same pixel sequence as scenario 2; outputs and RGB_out constant between ticks; frame_done after 144 clks.
5. **Mid-frame reset:** assert rst at h=2, v=1 → all outputs at reset values on the next clk; with frame_valid=1, the scan restarts at rd_addr {0,0}.
6. **frame_valid drops mid-frame:** frame_valid falls at v=1 → the frame completes all 48 ticks, frame_done pulses, then IDLE with no further rd_en.

Source files
------------

// File: rtl/frame_scanout.sv
// frame_scanout: raster read-out of the {y,x}-addressed pixel RAM with display timing and a frame_valid start/stop handshake.
// Latency: rd_en/rd_addr are combinational on an en tick; X/Y/de/sync/RGB_out follow one edge later. There is no backpressure: a sparse en simply stretches the raster.
module frame_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIX_W    = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             frame_valid,
  output logic             rd_en,
  output logic [19:0]      rd_addr,
  input  logic [PIX_W-1:0] rd_data,
  output logic [PIX_W-1:0] RGB_out,
  output logic [9:0]       X,
  output logic [9:0]       Y,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_done
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG    = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG    = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("frame_scanout: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic        r_de;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_frame_done;

  logic [10:0] w_h_ext;
  logic [10:0] w_v_ext;
  logic        w_active;
  logic        w_hs_n;
  logic        w_vs_n;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_eof;
  logic        w_tick;

  // Compare in 11 bits so a 1024-wide active region still decodes correctly.
  assign w_h_ext  = {1'b0, r_h_cnt};
  assign w_v_ext  = {1'b0, r_v_cnt};
  assign w_active = (w_h_ext < H_ACT_END) && (w_v_ext < V_ACT_END);
  assign w_hs_n   = !((w_h_ext >= HS_BEG) && (w_h_ext < HS_END));
  assign w_vs_n   = !((w_v_ext >= VS_BEG) && (w_v_ext < VS_END));
  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);
  assign w_eof    = w_h_last && w_v_last;
  assign w_tick   = en && (r_state == S_SCAN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Leaving SCAN only happens at end of frame, so a falling frame_valid never truncates a frame.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (frame_valid) w_state_nxt = S_SCAN;
      S_SCAN:  if (w_tick && w_eof && !frame_valid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en   = w_tick && w_active;
    rd_addr = {r_v_cnt, r_h_cnt};
  end

  always_ff @(posedge clk) begin
    if (rst || r_state == S_IDLE) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_tick) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  // The output stage also parks at its idle values on the edge that drops back to IDLE.
  always_ff @(posedge clk) begin
    if (rst || w_state_nxt == S_IDLE) begin
      r_x     <= '0;
      r_y     <= '0;
      r_de    <= 1'b0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (w_tick) begin
      r_x     <= r_h_cnt;
      r_y     <= r_v_cnt;
      r_de    <= w_active;
      r_hsync <= w_hs_n;
      r_vsync <= w_vs_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_tick && w_eof;
    end
  end

  assign X          = r_x;
  assign Y          = r_y;
  assign de         = r_de;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign frame_done = r_frame_done;
  assign RGB_out    = r_de ? rd_data : '0;

endmodule

// File: tb/tb_frame_scanout.sv
// Directed bench for frame_scanout on an 8x6 raster (4x3 visible) with a registered {y,x}-keyed RAM model.
module tb_frame_scanout;

  localparam int PW = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          frame_valid = 1'b0;
  logic          rd_en;
  logic [19:0]   rd_addr;
  logic [PW-1:0] rd_data = '0;
  logic [PW-1:0] RGB_out;
  logic [9:0]    X;
  logic [9:0]    Y;
  logic          de;
  logic          hsync;
  logic          vsync;
  logic          frame_done;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  frame_scanout #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .PIX_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .frame_valid(frame_valid),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .RGB_out(RGB_out), .X(X), .Y(Y), .de(de),
    .hsync(hsync), .vsync(vsync), .frame_done(frame_done)
  );

  function automatic logic [14:0] pix(input int v, input int h);
    return 15'(v * 100 + h * 7 + 11);
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= pix(int'(rd_addr[19:10]), int'(rd_addr[9:0]));

  function automatic logic [63:0] bundle(input bit hs, input bit vs, input bit d,
                                         input logic [9:0] x, input logic [9:0] y,
                                         input logic [14:0] rgb);
    return {26'd0, hs, vs, d, x, y, rgb};
  endfunction

  function automatic logic [63:0] dut_outs();
    return {26'd0, hsync, vsync, de, X, Y, RGB_out};
  endfunction

  function automatic logic [63:0] exp_at(input int h, input int v);
    bit a;
    a = (h < 4) && (v < 3);
    return bundle(!(h >= 5 && h <= 6), v != 4, a, 10'(h), 10'(v), a ? pix(v, h) : 15'd0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input string tag, input int n);
    logic [63:0] idle_b;
    idle_b = bundle(1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 15'd0);
    en = 1'b1;
    frame_valid = 1'b0;
    repeat (n) begin
      cyc();
      chk(tag, dut_outs(), idle_b);
      chk({tag, "_ctl"}, {frame_done, rd_en}, 2'b00);
    end
  endtask

  // Runs n ticks of a frame already in SCAN; gap idle clks precede each tick.
  // frame_valid is driven high on ticks whose line is below fv_until_v.
  task automatic scan_frame(input string tag, input int n, input int gap,
                            input int fv_until_v, output int fd_clk);
    logic [63:0] exp_o;
    logic [63:0] idle_b;
    int h, v, nclk, nrd;
    bit a, last, fv;
    idle_b = bundle(1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 15'd0);
    exp_o = idle_b;
    h = 0; v = 0; nclk = 0; nrd = 0; fd_clk = -1;
    for (int t = 0; t < n; t++) begin
      for (int g = 0; g < gap; g++) begin
        en = 1'b0;
        #1;
        chk({tag, "_gap_rden"}, rd_en, 0);
        cyc();
        nclk++;
        chk({tag, "_hold"}, dut_outs(), exp_o);
        chk({tag, "_gap_fd"}, frame_done, 0);
      end
      fv = (v < fv_until_v);
      en = 1'b1;
      frame_valid = fv;
      #1;
      a = (h < 4) && (v < 3);
      chk({tag, "_rden"}, rd_en, a);
      if (a) begin
        nrd++;
        chk({tag, "_addr"}, rd_addr, {10'(v), 10'(h)});
      end
      last = (h == 7) && (v == 5);
      cyc();
      nclk++;
      exp_o = (last && !fv) ? idle_b : exp_at(h, v);
      chk({tag, "_out"}, dut_outs(), exp_o);
      chk({tag, "_fd"}, frame_done, last);
      if (frame_done) fd_clk = nclk;
      if (h == 7) begin
        h = 0;
        v = (v == 5) ? 0 : v + 1;
      end else begin
        h++;
      end
    end
    if (n == 48) chk({tag, "_nrd"}, nrd, 12);
  endtask

  initial begin
    int fd;
    int fd2;

    // Reset and idle
    rst = 1'b1; en = 1'b1; frame_valid = 1'b0;
    repeat (3) cyc();
    chk("reset_outs", dut_outs(), bundle(1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 15'd0));
    chk("reset_ctl", {frame_done, rd_en}, 2'b00);
    rst = 1'b0;
    idle_check("idle", 20);

    // Single frame, frame_valid pulsed for one clk
    frame_valid = 1'b1;
    cyc();
    frame_valid = 1'b0;
    scan_frame("single", 48, 0, 0, fd);
    chk("single_fd_clk", fd, 48);
    idle_check("single_idle", 5);

    // Back-to-back frames
    frame_valid = 1'b1;
    cyc();
    scan_frame("b2b1", 48, 0, 99, fd);
    scan_frame("b2b2", 48, 0, 0, fd2);
    chk("b2b_fd1_clk", fd, 48);
    chk("b2b_fd2_clk", fd2, 48);
    idle_check("b2b_idle", 5);

    // Sparse en: one tick every third clk
    en = 1'b0;
    frame_valid = 1'b1;
    cyc();
    frame_valid = 1'b0;
    scan_frame("sparse", 48, 2, 0, fd);
    chk("sparse_fd_clk", fd, 144);
    idle_check("sparse_idle", 5);

    // Mid-frame reset at h=2, v=1
    frame_valid = 1'b1;
    cyc();
    scan_frame("pre_rst", 10, 0, 99, fd);
    rst = 1'b1;
    cyc();
    chk("midrst_outs", dut_outs(), bundle(1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 15'd0));
    chk("midrst_ctl", {frame_done, rd_en}, 2'b00);
    rst = 1'b0;
    frame_valid = 1'b1;
    cyc();
    scan_frame("post_rst", 48, 0, 0, fd);
    chk("post_rst_fd_clk", fd, 48);
    idle_check("post_rst_idle", 5);

    // frame_valid drops at line 1
    frame_valid = 1'b1;
    cyc();
    scan_frame("drop", 48, 0, 1, fd);
    chk("drop_fd_clk", fd, 48);
    idle_check("drop_idle", 10);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
